// File: rtl/spi_flash_uart_writer.sv
// UART-to-SPI-flash programmer: every received byte is written at an auto-incrementing
// address, read back, and echoed on UART TX, with a saturating count of read-back mismatches.
module spi_flash_uart_writer #(
  parameter logic [31:0] START_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_LIMIT = 32'h00FF_FFFF
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iRxReady,
  input  logic [7:0]  iRxData,
  output logic        oRxRd,
  output logic        oFlashWr,
  output logic        oFlashRd,
  output logic [31:0] oFlashAddr,
  output logic [7:0]  oFlashData,
  input  logic [7:0]  iFlashData,
  input  logic        iFlashDone,
  output logic        oTxStart,
  output logic [7:0]  oTxData,
  input  logic        iTxFull,
  output logic        oBusy,
  output logic [7:0]  oErrCount,
  output logic        oMismatch
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT_WR, S_WAIT_RD, S_TX} state_t;

  state_t      state_q, state_d;
  logic        rx_rd_q, rx_rd_d;
  logic        flash_wr_q, flash_wr_d;
  logic        flash_rd_q, flash_rd_d;
  logic        tx_start_q, tx_start_d;
  logic        busy_q, busy_d;
  logic        mis_q, mis_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  err_q, err_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a);
    return (a == ADDR_LIMIT) ? START_ADDR : a + 32'd1;
  endfunction

  always_comb begin
    state_d    = state_q;
    rx_rd_d    = 1'b0;
    flash_wr_d = 1'b0;
    flash_rd_d = 1'b0;
    tx_start_d = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tx_data_d  = tx_data_q;
    err_d      = err_q;
    mis_d      = mis_q;
    case (state_q)
      S_IDLE: begin
        if (iRxReady) begin
          wdata_d    = iRxData;
          rx_rd_d    = 1'b1;
          flash_wr_d = 1'b1;
          state_d    = S_WAIT_WR;
        end
      end
      S_WAIT_WR: begin
        if (iFlashDone) begin
          flash_rd_d = 1'b1;
          state_d    = S_WAIT_RD;
        end
      end
      S_WAIT_RD: begin
        if (iFlashDone) begin
          tx_data_d = iFlashData;
          // Non-erased locations read back wrong; that is reported, not retried.
          if (iFlashData != wdata_q) begin
            err_d = sat_inc(err_q);
            mis_d = 1'b1;
          end
          state_d = S_TX;
        end
      end
      S_TX: begin
        if (!iTxFull) begin
          tx_start_d = 1'b1;
          addr_d     = next_addr(addr_q);
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Busy also covers the echo-push cycle so it drops only after the byte is gone.
    busy_d = (state_d != S_IDLE) || tx_start_d;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q    <= S_IDLE;
      rx_rd_q    <= 1'b0;
      flash_wr_q <= 1'b0;
      flash_rd_q <= 1'b0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      mis_q      <= 1'b0;
      addr_q     <= START_ADDR;
      wdata_q    <= 8'h00;
      tx_data_q  <= 8'h00;
      err_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      rx_rd_q    <= rx_rd_d;
      flash_wr_q <= flash_wr_d;
      flash_rd_q <= flash_rd_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      mis_q      <= mis_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tx_data_q  <= tx_data_d;
      err_q      <= err_d;
    end
  end

  assign oRxRd      = rx_rd_q;
  assign oFlashWr   = flash_wr_q;
  assign oFlashRd   = flash_rd_q;
  assign oFlashAddr = addr_q;
  assign oFlashData = wdata_q;
  assign oTxStart   = tx_start_q;
  assign oTxData    = tx_data_q;
  assign oBusy      = busy_q;
  assign oErrCount  = err_q;
  assign oMismatch  = mis_q;

endmodule

// File: doc/spi_flash_uart_writer.md
# spi_flash_uart_writer

Write-path companion to the flash read test: pops bytes received on the UART RX FIFO, programs each into SPI flash at an auto-incrementing address, reads the same location back, and echoes the read-back byte on UART TX. Sits between the `uart` instance (RX/TX ports) and the `SpiFlash` controller (`iWr`/`iRd`/`iAddr`/`iDataIn`/`oDataOut`/`oDone`). It counts read-back mismatches so a host can verify programming over the serial link.

## Interface
- `START_ADDR`, default 32'h0000_0000: first flash address written after reset and the wrap target.
- `ADDR_LIMIT`, default 32'h00FF_FFFF: last address written before wrapping to `START_ADDR`.
- `iClk`  in  1  system clock; all logic on its rising edge.
- `iRst`  in  1  reset, asynchronous, active-high.
- `iRxReady`  in  1  UART RX FIFO not empty; `iRxData` is valid whenever this is high.
- `iRxData`  in  8  head byte of the RX FIFO.
- `oRxRd`  out  1  one-cycle pop strobe to the RX FIFO.
- `oFlashWr`  out  1  one-cycle write request to the flash controller.
- `oFlashRd`  out  1  one-cycle read request to the flash controller.
- `oFlashAddr`  out  32  flash address for the current request.
- `oFlashData`  out  8  byte to program.
- `iFlashData`  in  8  byte returned by the flash controller; valid when `iFlashDone`=1.
- `iFlashDone`  in  1  one-cycle completion pulse from the flash controller.
- `oTxStart`  out  1  one-cycle push strobe to the UART TX FIFO.
- `oTxData`  out  8  byte to transmit; held between pushes.
- `iTxFull`  in  1  UART TX FIFO full.
- `oBusy`  out  1  high in every state except S_IDLE.
- `oErrCount`  out  8  read-back mismatch count, saturating at 8'hFF.
- `oMismatch`  out  1  sticky; set on the first mismatch and cleared only by reset.

## Operation
- All outputs are registered. Reset values: strobes 0, `oFlashAddr`=`START_ADDR`, `oFlashData`=0, `oTxData`=0, `oErrCount`=0, `oMismatch`=0, state S_IDLE.
- S_IDLE: when `iRxReady`=1, latch `iRxData` into `oFlashData`, pulse `oRxRd` and `oFlashWr` together for one cycle, then go to S_WAIT_WR.
- S_WAIT_WR: wait for `iFlashDone`. On done, pulse `oFlashRd` for one cycle with the address unchanged, then go to S_WAIT_RD.
- S_WAIT_RD: on `iFlashDone`, latch `iFlashData` into `oTxData`.
  - If `iFlashData` != `oFlashData`, increment `oErrCount` (unless it is at 8'hFF) and set `oMismatch`.
  - Then go to S_TX.
- S_TX: if `iTxFull`=0, pulse `oTxStart`, advance the address, and return to S_IDLE. If `iTxFull`=1, stay in S_TX with `oTxStart`=0.
- Address advance: if `oFlashAddr`==`ADDR_LIMIT`, the next address is `START_ADDR`; otherwise it is `oFlashAddr`+1, in 32-bit arithmetic.
- Write-enable, status polling and erase are handled by the flash controller or by the host; this block does not erase. A location that was not erased reads back wrong, and that counts as a mismatch.
- `iFlashDone` is ignored in S_IDLE and S_TX. `iRxReady` is ignored outside S_IDLE, so the block has at most one byte in flight.
- Reset mid-operation: the block returns to reset values immediately. Any byte popped but not yet echoed is lost. The flash controller shares `iRst`.

## Timing
- Edge E0 (S_IDLE, `iRxReady`=1): in the following cycle `oRxRd`=`oFlashWr`=1, `oFlashData`=byte, `oBusy`=1.
- Write `iFlashDone` sampled at edge E1: `oFlashRd`=1 during cycle E1+1.
- Read `iFlashDone` sampled at edge E2: `oTxData` and the error flags are updated in cycle E2+1.
- `oTxStart` is high in cycle E2+2 at the earliest, or one cycle after `iTxFull` is sampled low.
- The address increments in the same cycle `oTxStart` is high. `oBusy` drops in the next cycle.
- Minimum per-byte overhead beyond the flash latency is 4 cycles.
- `iFlashDone` must not be asserted in the same cycle as the request strobe that it completes.
- Back-to-back: if `iRxReady` stays high, the next pop happens in the cycle after S_IDLE is re-entered.

## Test plan
- Single byte, no errors: RX 8'hA5, flash model echoes it, `iTxFull`=0. Expect one `oRxRd`, `oFlashWr` at addr 0, `oFlashRd` at addr 0, and `oTxStart` with 8'hA5. Then `oFlashAddr`=1, `oErrCount`=0.
- Mismatch: RX 8'h3C, flash returns 8'hFF. Expect `oTxData`=8'hFF, `oErrCount`=1, `oMismatch`=1. A following matching byte leaves `oMismatch`=1 and `oErrCount`=1.
- TX backpressure: `iTxFull`=1 for 20 cycles after read done. Expect the block to stay in S_TX with `oTxStart`=0 and `oBusy`=1. `oTxStart` is high exactly one cycle after `iTxFull` falls.
- Wrap and saturation: `START_ADDR`=32'h10, `ADDR_LIMIT`=32'h12, 4 bytes. Expect write addresses 10, 11, 12, 10. Separately, 300 mismatching bytes leave `oErrCount`=8'hFF.
- Stray and simultaneous events: an `iFlashDone` pulse in S_IDLE causes no strobe. `iRxReady` held high during a transfer produces exactly one `oRxRd` per completed echo.
- Reset mid-operation: assert `iRst` in S_WAIT_RD. All outputs return to reset values asynchronously, and the next byte is written to `START_ADDR`.
